// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the FSM encoding, the NOP word and the reset PC.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0100_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_hold_buf.sv
// One-entry skid buffer for a fetched word and its PC.
// Catches an ack that arrives while the decoder is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Entry register: clear/unload empty it, load fills it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full  <= 1'b0;
      instr <= NOP;
      pc    <= 32'h0;
    end else if (clear || unload) begin
      full  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, single outstanding
// imem request, registered output to the decoder.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic        w_imem_req,
  output logic [31:0] w_imem_addr_32,
  input  logic        w_imem_ack,
  input  logic [31:0] w_imem_rdata_32,
  input  logic        w_stall,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc_32,
  output logic [31:0] w_instr_32,
  output logic [31:0] w_pc_32,
  output logic        w_valid
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic [31:0]  instr_nx, opc_nx;
  logic         valid_nx;
  logic         can_load, consume;
  logic         hb_load, hb_unload, hb_clear, hb_full;
  logic [31:0]  hb_instr, hb_pc;

  assign can_load       = !w_valid || !w_stall;
  assign consume        = w_valid && !w_stall;
  assign w_imem_req     = (state == S_REQ);
  assign w_imem_addr_32 = pc;

  fetch_hold_buf u_hold (
    .clock    (clock),
    .reset    (reset),
    .load     (hb_load),
    .unload   (hb_unload),
    .clear    (hb_clear),
    .instr_in (w_imem_rdata_32),
    .pc_in    (pc),
    .full     (hb_full),
    .instr    (hb_instr),
    .pc       (hb_pc)
  );

  // Next state, next PC and next output register contents
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    instr_nx  = w_instr_32;
    opc_nx    = w_pc_32;
    valid_nx  = w_valid;
    hb_load   = 1'b0;
    hb_unload = 1'b0;
    hb_clear  = 1'b0;
    if (consume) begin
      valid_nx = 1'b0;
      instr_nx = NOP;
    end
    if (w_redirect) begin
      pc_nx    = align_pc(w_redirect_pc_32);
      valid_nx = 1'b0;
      instr_nx = NOP;
      hb_clear = 1'b1;
      if (state == S_REQ ||
          ((state == S_WAIT || state == S_DRAIN) &&
           !w_imem_ack))
        state_nx = S_DRAIN;
      else
        state_nx = S_REQ;
    end else begin
      case (state)
        S_IDLE: state_nx = S_REQ;
        S_REQ:  state_nx = S_WAIT;
        S_WAIT: begin
          if (w_imem_ack) begin
            pc_nx = pc + 32'd4;
            if (can_load) begin
              instr_nx = w_imem_rdata_32;
              opc_nx   = pc;
              valid_nx = 1'b1;
              state_nx = S_REQ;
            end else begin
              hb_load  = 1'b1;
              state_nx = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (can_load && hb_full) begin
            instr_nx  = hb_instr;
            opc_nx    = hb_pc;
            valid_nx  = 1'b1;
            hb_unload = 1'b1;
            state_nx  = S_REQ;
          end
        end
        S_DRAIN: begin
          if (w_imem_ack)
            state_nx = S_REQ;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State, PC and decoder-facing output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= PC_RESET;
      w_instr_32 <= NOP;
      w_pc_32    <= 32'h0;
      w_valid    <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      w_instr_32 <= instr_nx;
      w_pc_32    <= opc_nx;
      w_valid    <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model, stream scoreboard,
// directed scenarios followed by randomized stall/redirect.
module tb_fetch_stage;

  localparam logic [31:0] PC_RST = 32'h0100_0000;

  logic        clock, reset;
  logic        w_imem_req, w_imem_ack;
  logic [31:0] w_imem_addr_32, w_imem_rdata_32;
  logic        w_stall, w_redirect, w_valid;
  logic [31:0] w_redirect_pc_32, w_instr_32, w_pc_32;

  int n_chk = 0;
  int n_fail = 0;
  int n_pop = 0;
  int mem_lat = 1;
  bit mem_rand = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  logic [31:0] mon_e;
  logic [31:0] instr0, pc0;
  int          nreq;

  fetch_stage dut (
    .clock            (clock),
    .reset            (reset),
    .w_imem_req       (w_imem_req),
    .w_imem_addr_32   (w_imem_addr_32),
    .w_imem_ack       (w_imem_ack),
    .w_imem_rdata_32  (w_imem_rdata_32),
    .w_stall          (w_stall),
    .w_redirect       (w_redirect),
    .w_redirect_pc_32 (w_redirect_pc_32),
    .w_instr_32       (w_instr_32),
    .w_pc_32          (w_pc_32),
    .w_valid          (w_valid)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == PC_RST) return 32'h2402_0005;
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Expected in-order stream of fetched PCs from the current start
  function automatic void topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] p);
    exp_q.delete();
    exp_tail = p;
    topup();
  endfunction

  task automatic chk_rst(input string nm);
    check({nm, "_req"}, {31'b0, w_imem_req}, 32'd0);
    check({nm, "_addr"}, w_imem_addr_32, PC_RST);
    check({nm, "_instr"}, w_instr_32, 32'h0);
    check({nm, "_pc"}, w_pc_32, 32'h0);
    check({nm, "_valid"}, {31'b0, w_valid}, 32'd0);
  endtask

  task automatic wait_req(input string nm);
    int k;
    k = 0;
    @(negedge clock);
    while (!w_imem_req && k < 60) begin
      @(negedge clock);
      k++;
    end
    check({nm, "_seen"}, {31'b0, w_imem_req}, 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    @(negedge clock);
    while (!w_valid && k < 60) begin
      @(negedge clock);
      k++;
    end
    check({nm, "_seen"}, {31'b0, w_valid}, 32'd1);
  endtask

  // Instruction memory: accepts a request on the edge where req=1,
  // pulses ack with the word 'latency' cycles later
  initial begin : mem_model
    logic        req_n;
    logic [31:0] addr_n, paddr;
    int          cnt;
    w_imem_ack = 0;
    w_imem_rdata_32 = 0;
    cnt = 0;
    paddr = 0;
    forever begin
      @(negedge clock);
      req_n  = w_imem_req;
      addr_n = w_imem_addr_32;
      @(posedge clock);
      #1;
      w_imem_ack = 0;
      if (req_n) begin
        paddr = addr_n;
        cnt = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          w_imem_ack = 1;
          w_imem_rdata_32 = mem_word(paddr);
        end
      end
    end
  end

  // Scoreboard monitor: compare every word the decoder takes
  always @(negedge clock) begin
    if (!reset) begin
      if (!w_valid)
        check("nop_when_invalid", w_instr_32, 32'h0);
      else if (!w_stall && !w_redirect) begin
        mon_e = exp_q.pop_front();
        topup();
        n_pop++;
        check("sb_pc", w_pc_32, mon_e);
        check("sb_instr", w_instr_32, mem_word(mon_e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    w_stall = 0;
    w_redirect = 0;
    w_redirect_pc_32 = 0;
    restart(PC_RST);
    #1;
    chk_rst("reset");
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // First fetch with 1-cycle memory
    wait_req("first_req");
    check("first_addr", w_imem_addr_32, PC_RST);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("first_valid", {31'b0, w_valid}, 32'd1);
    check("first_instr", w_instr_32, 32'h2402_0005);
    check("first_pc", w_pc_32, PC_RST);
    check("next_addr", w_imem_addr_32, 32'h0100_0004);

    // Stall for 5 cycles while the next ack arrives
    instr0 = w_instr_32;
    pc0 = w_pc_32;
    w_stall = 1;
    nreq = 0;
    repeat (5) begin
      @(negedge clock);
      if (w_imem_req) nreq++;
      check("stall_pc", w_pc_32, pc0);
      check("stall_instr", w_instr_32, instr0);
    end
    check("stall_req_cnt", nreq, 32'd1);
    @(posedge clock);
    #1 w_stall = 0;
    @(posedge clock);
    #1;
    check("unstall_valid", {31'b0, w_valid}, 32'd1);
    check("unstall_pc", w_pc_32, pc0 + 32'd4);

    // Redirect in S_WAIT with 3-cycle memory
    mem_lat = 3;
    wait_req("rd_req");
    @(posedge clock);
    #1;
    w_redirect = 1;
    w_redirect_pc_32 = 32'h0100_0042;
    restart(32'h0100_0040);
    @(posedge clock);
    #1 w_redirect = 0;
    check("rd_valid", {31'b0, w_valid}, 32'd0);
    wait_req("rd_req2");
    check("rd_addr", w_imem_addr_32, 32'h0100_0040);
    wait_valid("rd_out");
    check("rd_out_pc", w_pc_32, 32'h0100_0040);

    // Redirect in the same cycle as the ack
    mem_lat = 1;
    wait_req("ra_req");
    @(posedge clock);
    #1;
    w_redirect = 1;
    w_redirect_pc_32 = 32'h0200_0010;
    restart(32'h0200_0010);
    @(posedge clock);
    #1 w_redirect = 0;
    check("ra_valid", {31'b0, w_valid}, 32'd0);
    check("ra_req", {31'b0, w_imem_req}, 32'd1);
    check("ra_addr", w_imem_addr_32, 32'h0200_0010);

    // Reset in S_WAIT; the late ack lands in S_IDLE
    mem_lat = 2;
    wait_req("rst_req");
    @(posedge clock);
    #2 reset = 1;
    restart(PC_RST);
    #1 chk_rst("rst_mid");
    @(posedge clock);
    #1 reset = 0;
    wait_req("rst_req2");
    check("rst_addr", w_imem_addr_32, PC_RST);
    wait_valid("rst_out");
    check("rst_out_pc", w_pc_32, PC_RST);
    check("rst_out_instr", w_instr_32, 32'h2402_0005);

    // PC wrap at the top of the address space
    mem_lat = 1;
    @(posedge clock);
    #1;
    w_redirect = 1;
    w_redirect_pc_32 = 32'hFFFF_FFFE;
    restart(32'hFFFF_FFFC);
    @(posedge clock);
    #1 w_redirect = 0;
    wait_req("wrap_req");
    check("wrap_addr0", w_imem_addr_32, 32'hFFFF_FFFC);
    wait_req("wrap_req2");
    check("wrap_addr1", w_imem_addr_32, 32'h0000_0000);

    // Randomized stall, redirect and memory latency
    mem_rand = 1;
    repeat (3000) begin
      @(posedge clock);
      #1;
      w_stall = ($urandom % 10) < 3;
      w_redirect = ($urandom % 100) < 3;
      if (w_redirect) begin
        w_redirect_pc_32 = $urandom;
        restart(w_redirect_pc_32 & 32'hFFFF_FFFC);
      end
    end
    @(posedge clock);
    #1;
    w_stall = 0;
    w_redirect = 0;
    repeat (20) @(posedge clock);
    check("sb_progress", {31'b0, n_pop > 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly upstream of the decoder. It owns the program counter and issues single-outstanding requests to instruction memory. It presents each fetched word, with its PC and a valid flag, to the decoder through an output register. It also absorbs decode stalls and branch/jump redirects, and squashes any fetch in flight when a redirect arrives.

## Interface
- PC_RESET, 32'h0100_0000, PC value loaded on reset
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- w_imem_req  out  1  request strobe; address is accepted on the rising edge where this is 1
- w_imem_addr_32  out  32  request address (word-aligned PC)
- w_imem_ack  in  1  one-cycle pulse; w_imem_rdata_32 is valid in that cycle
- w_imem_rdata_32  in  32  fetched word
- w_stall  in  1  decode cannot consume this cycle
- w_redirect  in  1  branch/jump taken; flush and refetch
- w_redirect_pc_32  in  32  new PC; bits [1:0] are forced to 0
- w_instr_32  out  32  instruction to the decoder; 32'h0 (SLL r0,r0,0, a NOP) when invalid
- w_pc_32  out  32  PC of w_instr_32
- w_valid  out  1  w_instr_32 holds a real instruction

## Operation
- State machine states: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN.
- **Consume:** the decoder takes the output on any edge where w_valid=1 and w_stall=0.
- The output register can load when w_valid=0 or w_stall=0.
- **S_IDLE** (reset state) → S_REQ on the next edge.
- **S_REQ:** w_imem_req=1 and w_imem_addr_32=pc; next state is S_WAIT.
- **S_WAIT:** w_imem_req=0.
  - On w_imem_ack with the output able to load: w_instr_32←rdata, w_pc_32←pc, w_valid←1, pc←pc+4, next state S_REQ.
  - On w_imem_ack with the output blocked: the word is latched into a one-entry hold buffer (data and PC), pc←pc+4, next state S_HOLD.
- **S_HOLD:** no request is issued. When the output can load, the buffer moves to the output register and the state returns to S_REQ.
- **Output when nothing loads:** if the output is consumed and nothing loads that edge, w_valid←0 and w_instr_32←32'h0.
- **Redirect** has highest priority and overrides stall.
  - On the redirect edge: pc←{w_redirect_pc_32[31:2],2'b00}, w_valid←0, w_instr_32←0, hold buffer cleared.
  - Next state is S_DRAIN if a fetch is outstanding (state S_REQ or S_WAIT, with no ack in this cycle); otherwise S_REQ.
- **S_DRAIN:** waits for w_imem_ack, discards the data, then → S_REQ.
  - A second redirect during S_DRAIN updates pc and stays in S_DRAIN.
- An ack outside S_WAIT/S_DRAIN is a protocol error and is ignored.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: w_imem_req=0, w_imem_addr_32=PC_RESET, w_instr_32=0, w_pc_32=0, w_valid=0; pc=PC_RESET, state S_IDLE.
- Reset asserted mid-fetch returns to S_IDLE immediately; the outstanding ack after reset is ignored, because S_IDLE ignores ack.
- First request is issued 1 cycle after reset deasserts.
- Latency from request edge to w_valid=1 is (memory latency)+1 edges.
  - With 1-cycle memory: req at edge N, ack in cycle N+1, w_valid=1 after edge N+2.
- Peak throughput: one instruction per 2 cycles.
- w_imem_req and w_imem_addr_32 are combinational from state and pc; all other outputs are registered.
- Redirect and ack in the same S_WAIT cycle: the ack data is discarded, and the next state is S_REQ at the redirect PC.

## Structure
- Shared package/header (alongside the ISA code definitions) holds:
  - the state encodings
  - the NOP constant 32'h0000_0000
  - the PC_RESET default
- One sub-module: fetch_hold_buf, a one-entry data+PC buffer with load/unload/clear.

## Test plan
- Reset, 1-cycle memory returning 32'h2402_0005 at PC_RESET → w_valid=1, w_instr_32=32'h2402_0005, w_pc_32=32'h0100_0000 two edges after the first req; next req address 32'h0100_0004.
- w_stall=1 held for 5 cycles while an ack arrives:
  - state goes to S_HOLD and no new req is issued;
  - output stays at the old instruction;
  - on stall release the buffered word appears on the next edge in PC order.
- w_redirect=1 to 32'h0100_0042 while in S_WAIT with 3-cycle memory:
  - next request address is 32'h0100_0040;
  - the stale ack is dropped and never reaches w_valid.
- Redirect and ack in the same cycle → ack data is discarded, next req is issued at the redirect PC, w_valid=0.
- Reset asserted during S_WAIT → all outputs return to their reset values; a late ack is ignored; fetch restarts at PC_RESET.
- pc=32'hFFFF_FFFC, fetch completes → next req address 32'h0000_0000.
